echo_mixer: RTL and testbench

Downstream consumer of the delayed-audio buffer. On each audio sample strobe it subtracts a gain-scaled copy of the delayed sample (`echo_in`) from the live sample (`mic_in`), saturates the result, and emits it with a one-cycle valid pulse. Changes to the gain are ramped one step per sample, so enabling, disabling or retuning the echo path never produces a click. It sits between the delay buffer and the audio output/PWM stage.

---
 rtl/echo_mixer_if.sv | 27 ++
 rtl/echo_mixer.sv | 137 +++++++++++++
 tb/tb_echo_mixer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/echo_mixer_if.sv
// Signal bundle between the audio front end and echo_mixer.
// Strobe semantics: audio_valid_in is a one-cycle strobe with no ready/backpressure;
// a strobe is either accepted or dropped (overrun_out). out_valid is a one-cycle
// pulse that the consumer must take in the cycle it is high.
interface echo_mixer_if;
    logic               audio_valid_in;
    logic signed [15:0] mic_in;
    logic signed [15:0] echo_in;
    logic               enable_in;
    logic [8:0]         gain_in;
    logic signed [15:0] mix_out;
    logic               out_valid;
    logic               clip_out;
    logic               ramping_out;
    logic               overrun_out;
    logic [1:0]         state_dbg;

    modport master (
        output audio_valid_in, mic_in, echo_in, enable_in, gain_in,
        input  mix_out, out_valid, clip_out, ramping_out, overrun_out, state_dbg
    );

    modport slave (
        input  audio_valid_in, mic_in, echo_in, enable_in, gain_in,
        output mix_out, out_valid, clip_out, ramping_out, overrun_out, state_dbg
    );
endinterface

// File: rtl/echo_mixer.sv
// Echo canceller mix stage: mix = sat16(mic - (echo * gain) >>> 8), with the gain
// ramped one step per accepted sample so gain changes never click.
module echo_mixer #(
    parameter int ECHO_LAT  = 2,
    parameter int RAMP_STEP = 1
) (
    input logic        clk_in,
    input logic        rst_in,
    echo_mixer_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, HOLD = 2'd2} state_t;

    localparam logic [8:0] STEP      = 9'(RAMP_STEP);
    localparam logic [8:0] UNITY     = 9'd256;

    state_t             state_q, state_d;
    logic [8:0]         gain_cur, gain_d, tgt;
    logic [ECHO_LAT-1:0] dly_q;
    logic               e_v, p_v, d_v;
    logic               busy, accept;
    logic signed [15:0] mic_q, mic_p, echo_q;
    logic [8:0]         gain_q;
    logic signed [25:0] echo_ext, gain_ext, prod_d, prod_q;
    logic signed [17:0] diff_q;
    logic signed [15:0] sat_val;
    logic               sat_clip;
    logic               overrun_q, out_valid_q, clip_q;
    logic signed [15:0] mix_q;

    // Target gain: zero when disabled, otherwise gain_in clamped to unity.
    always_comb begin
        tgt = '0;
        if (bus.enable_in) tgt = (bus.gain_in > UNITY) ? UNITY : bus.gain_in;
    end

    // The busy window covers the strobe's pipeline up to (not including) the cycle
    // whose edge fires out_valid, so a strobe in that cycle is accepted.
    assign busy   = (|dly_q) | e_v | p_v;
    assign accept = bus.audio_valid_in & ~busy;

    // Next state from gain_cur/tgt; gain steps toward tgt only on accepted strobes.
    always_comb begin
        state_d = IDLE;
        gain_d  = gain_cur;
        if (gain_cur != tgt)  state_d = RAMP;
        else if (tgt != '0)   state_d = HOLD;
        if (accept) begin
            if (gain_cur < tgt)
                gain_d = ((tgt - gain_cur) <= STEP) ? tgt : gain_cur + STEP;
            else if (gain_cur > tgt)
                gain_d = ((gain_cur - tgt) <= STEP) ? tgt : gain_cur - STEP;
        end
    end

    // State and current gain registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= IDLE;
            gain_cur <= '0;
        end else begin
            state_q  <= state_d;
            gain_cur <= gain_d;
        end
    end

    assign echo_ext = {{10{echo_q[15]}}, echo_q};
    assign gain_ext = {17'd0, gain_q};
    assign prod_d   = echo_ext * gain_ext;

    // Sample pipeline: capture, wait for echo, multiply, subtract.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            dly_q  <= '0;
            e_v    <= 1'b0;
            p_v    <= 1'b0;
            d_v    <= 1'b0;
            mic_q  <= '0;
            mic_p  <= '0;
            gain_q <= '0;
            echo_q <= '0;
            prod_q <= '0;
            diff_q <= '0;
        end else begin
            dly_q[0] <= accept;
            for (int i = 1; i < ECHO_LAT; i++) dly_q[i] <= dly_q[i-1];
            if (accept) begin
                mic_q  <= bus.mic_in;
                gain_q <= gain_cur;
            end
            e_v <= dly_q[ECHO_LAT-1];
            if (dly_q[ECHO_LAT-1]) echo_q <= bus.echo_in;
            p_v <= e_v;
            if (e_v) begin
                prod_q <= prod_d;
                mic_p  <= mic_q;
            end
            d_v <= p_v;
            // prod_q[25:8] is prod >>> 8 (floor toward minus infinity).
            if (p_v) diff_q <= {{2{mic_p[15]}}, mic_p} - prod_q[25:8];
        end
    end

    // Saturate the 18-bit difference to 16 bits.
    always_comb begin
        sat_val  = diff_q[15:0];
        sat_clip = 1'b0;
        if (diff_q[17] && !(&diff_q[16:15])) begin
            sat_val  = 16'sh8000;
            sat_clip = 1'b1;
        end else if (!diff_q[17] && (|diff_q[16:15])) begin
            sat_val  = 16'sh7fff;
            sat_clip = 1'b1;
        end
    end

    // Output stage and sticky overrun flag.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mix_q       <= '0;
            out_valid_q <= 1'b0;
            clip_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= d_v;
            clip_q      <= d_v & sat_clip;
            if (d_v) mix_q <= sat_val;
            if (bus.audio_valid_in && busy) overrun_q <= 1'b1;
        end
    end

    assign bus.mix_out     = mix_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.clip_out    = clip_q;
    assign bus.overrun_out = overrun_q;
    assign bus.ramping_out = (state_q == RAMP);
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_echo_mixer.sv
// Directed bench for echo_mixer: vector table plus hand sequences for ramping,
// overrun and reset in flight.
module tb_echo_mixer;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;

    echo_mixer_if bus();

    echo_mixer #(.ECHO_LAT(2), .RAMP_STEP(1)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    // Clock / reset block.
    always #5 clk_in = ~clk_in;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic en;
        int   gin;
        int   mic;
        int   echo;
        int   exp_mix;
        int   exp_clip;
    } vec_t;

    vec_t vecs[12];
    int   n_vec = 0;
    int   n_bad = 0;
    int   model_gain = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    function automatic int tgt_of(logic en, int gin);
        if (!en) return 0;
        return (gin > 256) ? 256 : gin;
    endfunction

    function automatic int step_to(int g, int t);
        if (g < t) return g + 1;
        if (g > t) return g - 1;
        return g;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Driver: one strobe, echo presented two cycles later, wait for out_valid.
    task automatic sample(input int m, input int e, output int mix, output int clip, output int lat);
        @(posedge clk_in); #1;
        bus.audio_valid_in = 1'b1;
        bus.mic_in  = 16'(m);
        bus.echo_in = 16'($urandom);
        @(posedge clk_in); #1;
        bus.audio_valid_in = 1'b0;
        bus.mic_in = 16'($urandom);
        model_gain = step_to(model_gain, tgt_of(bus.enable_in, int'(bus.gain_in)));
        lat = -1; mix = 0; clip = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_in); #1;
            if (k == 1) bus.echo_in = 16'(e);
            if (k == 2) bus.echo_in = 16'($urandom);
            if (bus.out_valid) begin
                lat  = k;
                mix  = int'(bus.mix_out);
                clip = int'(bus.clip_out);
                break;
            end
        end
    endtask

    task automatic settle(input logic en, input int gin);
        int m, c, l, guard;
        bus.enable_in = en;
        bus.gain_in   = 9'(gin);
        guard = 0;
        while (model_gain != tgt_of(en, gin) && guard < 600) begin
            sample($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768, m, c, l);
            guard++;
        end
    endtask

    // Two strobes s cycles apart with mic=0, echo=256; collects all out_valid pulses.
    task automatic two_strobes(input int s);
        got_q.delete();
        bus.mic_in  = 16'sd0;
        bus.echo_in = 16'sd256;
        for (int c = 0; c < s + 15; c++) begin
            @(posedge clk_in); #1;
            if (bus.out_valid) got_q.push_back(bus.mix_out);
            bus.audio_valid_in = (c == 0 || c == s);
        end
    endtask

    task automatic compare_pulses(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({name, "_value"}, int'($signed(got_q[i])), int'($signed(exp_q[i])));
        exp_q.delete();
    endtask

    initial begin
        int mix, clip, lat, pulses;
        int up_exp[6];
        int dn_exp[4];

        // Vector table: pass-through, unity gain with clamp, half gain floor cases.
        vecs[0]  = '{1'b0,  77,   1000,    500,   1000, 0};
        vecs[1]  = '{1'b0,  77, -32768,  32767, -32768, 0};
        vecs[2]  = '{1'b0,  77,  32767,     -1,  32767, 0};
        vecs[3]  = '{1'b1, 300,   1000,    300,    700, 0};
        vecs[4]  = '{1'b1, 300,  32767, -32768,  32767, 1};
        vecs[5]  = '{1'b1, 300, -32768,  32767, -32768, 1};
        vecs[6]  = '{1'b1, 300,      0,     -1,      1, 0};
        vecs[7]  = '{1'b1, 300,   -100,   -100,      0, 0};
        vecs[8]  = '{1'b1, 128,      0,     -1,      1, 0};
        vecs[9]  = '{1'b1, 128,      0,      3,     -1, 0};
        vecs[10] = '{1'b1, 128,      0,     -3,      2, 0};
        vecs[11] = '{1'b1, 128,    100,   1000,   -400, 0};
        up_exp = '{0, -1, -2, -3, -4, -4};
        dn_exp = '{-4, -3, -2, -1};

        bus.audio_valid_in = 1'b0;
        bus.mic_in = '0; bus.echo_in = '0;
        bus.enable_in = 1'b0; bus.gain_in = '0;

        // Reset held with random inputs: outputs stay at zero.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in); #1;
            bus.audio_valid_in = 1'($urandom);
            bus.mic_in    = 16'($urandom);
            bus.echo_in   = 16'($urandom);
            bus.enable_in = 1'($urandom);
            bus.gain_in   = 9'($urandom);
            @(negedge clk_in);
            check("rst_mix", int'(bus.mix_out), 0);
            check("rst_valid", int'(bus.out_valid), 0);
            check("rst_clip", int'(bus.clip_out), 0);
            check("rst_ramping", int'(bus.ramping_out), 0);
            check("rst_overrun", int'(bus.overrun_out), 0);
        end
        bus.audio_valid_in = 1'b0;
        bus.enable_in = 1'b0;
        bus.gain_in = '0;
        #1 rst_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in); #1;
            check("post_rst_ramping", int'(bus.ramping_out), 0);
            check("post_rst_valid", int'(bus.out_valid), 0);
        end

        // Ramp up to gain 4 and back down.
        bus.enable_in = 1'b1; bus.gain_in = 9'd4;
        repeat (2) @(posedge clk_in); #1;
        check("ramp_start", int'(bus.ramping_out), 1);
        for (int i = 0; i < 6; i++) begin
            sample(0, 256, mix, clip, lat);
            check("ramp_up_mix", mix, up_exp[i]);
            check("ramp_up_ramping", int'(bus.ramping_out), (i < 3) ? 1 : 0);
        end
        check("hold_state", int'(bus.state_dbg), 2);
        bus.enable_in = 1'b0;
        repeat (2) @(posedge clk_in); #1;
        check("ramp_down_start", int'(bus.ramping_out), 1);
        for (int i = 0; i < 4; i++) begin
            sample(0, 256, mix, clip, lat);
            check("ramp_dn_mix", mix, dn_exp[i]);
        end
        check("idle_ramping", int'(bus.ramping_out), 0);
        check("idle_state", int'(bus.state_dbg), 0);

        // Table-driven vectors.
        for (int i = 0; i < 12; i++) begin
            settle(vecs[i].en, vecs[i].gin);
            sample(vecs[i].mic, vecs[i].echo, mix, clip, lat);
            check($sformatf("vec%0d_latency", i), lat, 5);
            check($sformatf("vec%0d_mix", i), mix, vecs[i].exp_mix);
            check($sformatf("vec%0d_clip", i), clip, vecs[i].exp_clip);
        end

        // Strobes six cycles apart: both accepted, no overrun.
        bus.enable_in = 1'b1; bus.gain_in = 9'd200;
        exp_q.push_back(16'(-model_gain));
        exp_q.push_back(16'(-(model_gain + 1)));
        model_gain += 2;
        two_strobes(6);
        compare_pulses("spaced6");
        check("spaced6_overrun", int'(bus.overrun_out), 0);

        // Strobes three cycles apart: second dropped, overrun sticks, gain steps once.
        exp_q.push_back(16'(-model_gain));
        model_gain += 1;
        two_strobes(3);
        compare_pulses("overrun");
        check("overrun_flag", int'(bus.overrun_out), 1);
        sample(0, 256, mix, clip, lat);
        check("overrun_gain_once", mix, -(model_gain - 1));
        check("overrun_sticky", int'(bus.overrun_out), 1);

        // Reset while a sample is in flight.
        @(posedge clk_in); #1;
        bus.audio_valid_in = 1'b1;
        @(posedge clk_in); #1;
        bus.audio_valid_in = 1'b0;
        repeat (2) @(posedge clk_in); #1;
        rst_in = 1'b0;
        #1;
        check("midrst_overrun", int'(bus.overrun_out), 0);
        check("midrst_mix", int'(bus.mix_out), 0);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk_in); #1;
            if (c == 2) rst_in = 1'b1;
            if (bus.out_valid) pulses++;
        end
        check("midrst_pulses", pulses, 0);
        model_gain = 0;
        sample(1234, 256, mix, clip, lat);
        check("after_rst_latency", lat, 5);
        check("after_rst_mix", mix, 1234);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
